// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan driver (font, blank pattern, segment bit order, width helper)
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic int seg_clog2(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: nibble to active-low g..a segment pattern from the shared font
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // copy the font row into the cathode bit order a..g
  always_comb begin
    seg = SEG_BLANK;
    for (int s = SEG_A; s <= SEG_G; s++) seg[s] = SEG_FONT[nib][s];
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment driver with frame-aligned commit; optional SEG_DIM_EN adds bright[2:0] duty dimming
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  input  logic                  lzs,
`ifdef SEG_DIM_EN
  input  logic [2:0]            bright,
`endif
  output logic [6:0]            hex,
  output logic                  dp,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);
  localparam int IW = seg_clog2(DIGITS);
  localparam int PW = seg_clog2(REFRESH_DIV);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  fd_q, fd_d;
  logic [4*DIGITS-1:0]   pend_data_q, pend_data_d, sh_data_q, sh_data_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, sh_blank_q, sh_blank_d;
  logic                  pend_valid_q, pend_valid_d, sh_valid_q, sh_valid_d;
  logic [6:0]            hex_q, hex_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  tick, wrap;
  logic [3:0]            nib;
  logic [6:0]            font_seg;
  logic [DIGITS-1:0]     supp;
  logic                  run, dark, on;

  assign tick = presc_q == PW'(REFRESH_DIV - 1);
  assign wrap = tick && idx_q == IW'(DIGITS - 1);
  assign nib  = sh_data_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_font (.nib(nib), .seg(font_seg));

  // scan counters plus pending/shadow handoff; a load coinciding with a wrap goes straight to shadow
  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    fd_d         = wrap;
    pend_data_d  = load ? data_in  : pend_data_q;
    pend_dp_d    = load ? dp_in    : pend_dp_q;
    pend_blank_d = load ? blank_in : pend_blank_q;
    pend_valid_d = !wrap && (load || pend_valid_q);
    sh_data_d    = (wrap && load) ? data_in  : (wrap && pend_valid_q) ? pend_data_q  : sh_data_q;
    sh_dp_d      = (wrap && load) ? dp_in    : (wrap && pend_valid_q) ? pend_dp_q    : sh_dp_q;
    sh_blank_d   = (wrap && load) ? blank_in : (wrap && pend_valid_q) ? pend_blank_q : sh_blank_q;
    sh_valid_d   = sh_valid_q || (wrap && (load || pend_valid_q));
  end

  // output pattern for the selected digit: leading-zero run from the top, blanking, dimming window
  always_comb begin
    run  = 1'b1;
    supp = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run     = run && sh_data_q[4*i +: 4] == 4'h0 && !sh_dp_q[i];
      supp[i] = run;
    end
    dark = sh_blank_q[idx_q] || (lzs && supp[idx_q]);
`ifdef SEG_DIM_EN
    on   = int'(presc_q) * 8 < (int'(bright) + 1) * REFRESH_DIV;
`else
    on   = 1'b1;
`endif
    an_d  = (sh_valid_q && on) ? ~(DIGITS'(1) << idx_q) : '1;
    hex_d = (sh_valid_q && !dark) ? font_seg : SEG_BLANK;
    dp_d  = !(sh_valid_q && !dark && sh_dp_q[idx_q]);
  end

  // all state, cleared asynchronously so the display goes dark at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      fd_q         <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_valid_q   <= 1'b0;
      hex_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      fd_q         <= fd_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_valid_q   <= sh_valid_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign hex        = hex_q;
  assign dp         = dp_q;
  assign AN         = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scan, commit, LZS, dp/blank and reset for DIGITS=8, REFRESH_DIV=4
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        lzs = 1'b0;
`ifdef SEG_DIM_EN
  logic [2:0]  bright = 3'd7;
`endif
  logic [6:0]  hex;
  logic        dp;
  logic [7:0]  AN;
  logic        frame_done;
  int          n_tests = 0;
  int          n_fail = 0;

  localparam logic [55:0] DARK = {8{7'h7F}};

  seg_scan_driver #(.DIGITS(8), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .lzs(lzs),
`ifdef SEG_DIM_EN
    .bright(bright),
`endif
    .hex(hex), .dp(dp), .AN(AN), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    chk("fd_timeout", {31'b0, frame_done}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    data_in  = d;
    dp_in    = p;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic scan_frame(input string tag, input logic lit, input logic [55:0] eh, input logic [7:0] edp);
    logic [7:0] ea;
    wait_fd();
    @(negedge clk);
    chk({tag, "_fd_pulse"}, {31'b0, frame_done}, 32'd0);
    for (int d = 0; d < 8; d++) begin
      ea = lit ? ~(8'h01 << d) : 8'hFF;
      chk({tag, "_an"}, {24'b0, AN}, {24'b0, ea});
      chk({tag, "_hex"}, {25'b0, hex}, {25'b0, eh[7*d +: 7]});
      chk({tag, "_dp"}, {31'b0, dp}, {31'b0, edp[d]});
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'b0, AN}, 32'hFF);
    chk("rst_hex", {25'b0, hex}, 32'h7F);
    chk("rst_dp", {31'b0, dp}, 32'd1);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;

    scan_frame("idle0", 1'b0, DARK, 8'hFF);
    scan_frame("idle1", 1'b0, DARK, 8'hFF);
    wait_fd();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cnt++;
      if (frame_done) break;
    end
    chk("fd_period", cnt, 32);

    do_load(32'h89AB_CDEF, 8'h00, 8'h00);
    scan_frame("font", 1'b1, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF);

    wait_fd();
    repeat (9) @(negedge clk);
    do_load(32'h1111_1111, 8'h00, 8'h00);
    @(negedge clk);
    do_load(32'h2222_2222, 8'h00, 8'h00);
    chk("midframe_an", {24'b0, AN}, 32'hFB);
    chk("midframe_hex", {25'b0, hex}, 32'h21);
    scan_frame("last_wins", 1'b1, {8{7'h24}}, 8'hFF);

    lzs = 1'b1;
    do_load(32'h0000_0050, 8'h00, 8'h00);
    scan_frame("lzs_on", 1'b1, {{6{7'h7F}}, 7'h12, 7'h40}, 8'hFF);
    lzs = 1'b0;
    scan_frame("lzs_off", 1'b1, {{6{7'h40}}, 7'h12, 7'h40}, 8'hFF);

    do_load(32'h0000_0000, 8'h04, 8'h02);
    scan_frame("dp_blank", 1'b1, {{6{7'h40}}, 7'h7F, 7'h40}, 8'hFB);

    do_load(32'h1234_5678, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    chk("pre_rst_an", {24'b0, AN}, 32'hFD);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {24'b0, AN}, 32'hFF);
    chk("async_rst_hex", {25'b0, hex}, 32'h7F);
    chk("async_rst_dp", {31'b0, dp}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    scan_frame("post_rst", 1'b0, DARK, 8'hFF);
    do_load(32'h1234_5678, 8'h00, 8'h00);
    scan_frame("reload", 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hFF);

`ifdef SEG_DIM_EN
    bright = 3'd1;
    wait_fd();
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (AN != 8'hFF) cnt++;
      if (k == 0) chk("dim_an_lit", {24'b0, AN}, 32'hFE);
    end
    chk("dim_duty", cnt, 1);
    bright = 3'd7;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
